nv_nvdla_mcif_rd_ig_elastic_pipe: RTL and testbench

//  Parametrised elastic pipe stage for the MCIF read ingress path (bpt -> arb).

---
 rtl/nv_nvdla_mcif_rd_ig_elastic_pipe_pkg.sv | 18 +
 rtl/nv_nvdla_mcif_rd_ig_elastic_pipe_if.sv | 30 +++
 rtl/nv_nvdla_mcif_rd_ig_elastic_pipe_mem.sv | 26 ++
 rtl/nv_nvdla_mcif_rd_ig_elastic_pipe.sv | 106 ++++++++++
 tb/tb_nv_nvdla_mcif_rd_ig_elastic_pipe.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/nv_nvdla_mcif_rd_ig_elastic_pipe_pkg.sv
// Shared helpers and parameter limits for the MCIF read-ingress elastic pipe.
// Optional bypass build controlled by NV_NVDLA_MCIF_PIPE_BYPASS_EN (see top).
package nv_nvdla_mcif_pipe_pkg;

  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  // Occupancy counter must represent 0..DEPTH inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/nv_nvdla_mcif_rd_ig_elastic_pipe_if.sv
// Handshake bundle between the bpt-side producer, the elastic pipe and the arbiter.
// The pipe uses the slave modport; the environment driving it uses master.
interface nv_nvdla_mcif_rd_ig_elastic_pipe_if #(
  parameter int WIDTH = 75,
  parameter int DEPTH = 2
);
  import nv_nvdla_mcif_pipe_pkg::*;

  localparam int CNTW = cnt_w(DEPTH);

  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_pd;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_pd;
  logic [CNTW-1:0]  level;
  logic             afull;

  modport master (
    output in_vld, in_pd, out_rdy,
    input  in_rdy, out_vld, out_pd, level, afull
  );

  modport slave (
    input  in_vld, in_pd, out_rdy,
    output in_rdy, out_vld, out_pd, level, afull
  );

endinterface

// File: rtl/nv_nvdla_mcif_rd_ig_elastic_pipe_mem.sv
// DEPTH x WIDTH storage for the elastic pipe: one write port, one async read port.
// Contents are intentionally not reset; validity is tracked by the top.
module nv_nvdla_mcif_pipe_mem #(
  parameter int WIDTH = 75,
  parameter int DEPTH = 2,
  parameter int PTRW  = 1
) (
  input  logic             nvdla_core_clk,
  input  logic             wr_en_i,
  input  logic [PTRW-1:0]  wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTRW-1:0]  rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/nv_nvdla_mcif_rd_ig_elastic_pipe.sv
// DEPTH-entry elastic pipe for the MCIF read ingress path with registered in_rdy.
// Define NV_NVDLA_MCIF_PIPE_BYPASS_EN for a zero-latency path when empty.
module nv_nvdla_mcif_rd_ig_elastic_pipe #(
  parameter int WIDTH        = 75,
  parameter int DEPTH        = 2,
  parameter int AFULL_THRESH = 1
) (
  input  logic                               nvdla_core_clk,
  input  logic                               nvdla_core_rstn,
  nv_nvdla_mcif_rd_ig_elastic_pipe_if.slave  pipe_if
);
  import nv_nvdla_mcif_pipe_pkg::*;

  localparam int              CNTW      = cnt_w(DEPTH);
  localparam int              PTRW      = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_LVL  = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AFULL_LVL = CNTW'(DEPTH - AFULL_THRESH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
    $error("nv_nvdla_mcif_rd_ig_elastic_pipe: DEPTH out of range");
  end
  if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH - 1) begin : g_afull_chk
    $error("nv_nvdla_mcif_rd_ig_elastic_pipe: AFULL_THRESH out of range");
  end

  logic [CNTW-1:0]  level_q, level_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             out_vld_q;
  logic             in_rdy_q;
  logic             afull_q;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic [WIDTH-1:0] head_pd;

  assign push = pipe_if.in_vld & in_rdy_q;
  assign pop  = out_vld_q & pipe_if.out_rdy;

`ifdef NV_NVDLA_MCIF_PIPE_BYPASS_EN
  // Empty pipe presents the incoming beat directly; a same-cycle accept skips storage.
  logic bypass;
  assign bypass          = ~out_vld_q & pipe_if.in_vld;
  assign wr_en           = push & ~(bypass & pipe_if.out_rdy);
  assign pipe_if.out_vld = out_vld_q | pipe_if.in_vld;
  assign pipe_if.out_pd  = out_vld_q ? head_pd : pipe_if.in_pd;
`else
  assign wr_en           = push;
  assign pipe_if.out_vld = out_vld_q;
  assign pipe_if.out_pd  = head_pd;
`endif

  assign pipe_if.in_rdy = in_rdy_q;
  assign pipe_if.level  = level_q;
  assign pipe_if.afull  = afull_q;

  always_comb begin
    level_d  = level_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    case ({wr_en, pop})
      2'b10:   level_d = level_q + CNTW'(1);
      2'b01:   level_d = level_q - CNTW'(1);
      default: level_d = level_q;
    endcase
    if (wr_en) begin
      wr_ptr_d = PTRW'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end
    if (pop) begin
      rd_ptr_d = PTRW'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end
  end

  // Status flags are recomputed from level_d so they change together with level.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      level_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      out_vld_q <= 1'b0;
      in_rdy_q  <= 1'b1;
      afull_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      out_vld_q <= (level_d != '0);
      in_rdy_q  <= (level_d != FULL_LVL);
      afull_q   <= (level_d >= AFULL_LVL);
    end
  end

  nv_nvdla_mcif_pipe_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_mem (
    .nvdla_core_clk (nvdla_core_clk),
    .wr_en_i        (wr_en),
    .wr_addr_i      (wr_ptr_q),
    .wr_data_i      (pipe_if.in_pd),
    .rd_addr_i      (rd_ptr_q),
    .rd_data_o      (head_pd)
  );

endmodule

// File: tb/tb_nv_nvdla_mcif_rd_ig_elastic_pipe.sv
// Directed bench for the elastic pipe at DEPTH=3: vector table plus ordering,
// reset and (with NV_NVDLA_MCIF_PIPE_BYPASS_EN) bypass sequences.
module tb_nv_nvdla_mcif_rd_ig_elastic_pipe;

  localparam int W = 75;
  localparam int D = 3;
`ifdef NV_NVDLA_MCIF_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic nvdla_core_clk = 1'b0;
  logic nvdla_core_rstn;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  nv_nvdla_mcif_rd_ig_elastic_pipe_if #(.WIDTH(W), .DEPTH(D)) pipe_if ();

  nv_nvdla_mcif_rd_ig_elastic_pipe #(
    .WIDTH        (W),
    .DEPTH        (D),
    .AFULL_THRESH (1)
  ) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .pipe_if         (pipe_if)
  );

  typedef struct {
    logic         in_vld;
    logic         out_rdy;
    logic [W-1:0] in_pd;
    logic         e_out_vld;
    logic         e_in_rdy;
    logic [1:0]   e_level;
    logic         e_afull;
    logic [W-1:0] e_pd;
  } vec_t;

  localparam logic [W-1:0] PX   = {W{1'bx}};
  localparam logic [W-1:0] P0   = '0;
  localparam logic [W-1:0] P1234 = 75'h1234;
  localparam logic [W-1:0] A0   = {11'h7A0, 64'hDEAD_BEEF_0000_00A0};
  localparam logic [W-1:0] A1   = {11'h5A1, 64'h0123_4567_89AB_CDA1};
  localparam logic [W-1:0] A2   = {11'h2A2, 64'hFFFF_0000_FFFF_00A2};
  localparam logic [W-1:0] A3   = {11'h4A3, 64'h8000_0000_0000_00A3};
  localparam logic [W-1:0] B0   = {11'h1B0, 64'hCAFE_F00D_1234_00B0};

  vec_t vecs [15];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge nvdla_core_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    logic hold_v;
    logic [W-1:0] hold_pd;

    //                in  ordy pd     ovld      irdy lvl                  af    pd
    vecs[0]  = '{1'b0, 1'b0, PX,    1'b0,     1'b1, 2'd0,                1'b0, P0};
    vecs[1]  = '{1'b1, 1'b1, P1234, BYP,      1'b1, 2'd0,                1'b0, P1234};
    vecs[2]  = '{1'b0, 1'b1, PX,    !BYP,     1'b1, {1'b0, !BYP},        1'b0, P1234};
    vecs[3]  = '{1'b0, 1'b0, PX,    1'b0,     1'b1, 2'd0,                1'b0, P0};
    vecs[4]  = '{1'b1, 1'b0, A0,    BYP,      1'b1, 2'd0,                1'b0, A0};
    vecs[5]  = '{1'b1, 1'b0, A1,    1'b1,     1'b1, 2'd1,                1'b0, A0};
    vecs[6]  = '{1'b1, 1'b0, A2,    1'b1,     1'b1, 2'd2,                1'b1, A0};
    vecs[7]  = '{1'b1, 1'b0, A3,    1'b1,     1'b0, 2'd3,                1'b1, A0};
    vecs[8]  = '{1'b1, 1'b1, A3,    1'b1,     1'b0, 2'd3,                1'b1, A0};
    vecs[9]  = '{1'b1, 1'b0, A3,    1'b1,     1'b1, 2'd2,                1'b1, A1};
    vecs[10] = '{1'b0, 1'b1, PX,    1'b1,     1'b0, 2'd3,                1'b1, A1};
    vecs[11] = '{1'b0, 1'b1, PX,    1'b1,     1'b1, 2'd2,                1'b1, A2};
    vecs[12] = '{1'b1, 1'b1, B0,    1'b1,     1'b1, 2'd1,                1'b0, A3};
    vecs[13] = '{1'b0, 1'b1, PX,    1'b1,     1'b1, 2'd1,                1'b0, B0};
    vecs[14] = '{1'b0, 1'b0, PX,    1'b0,     1'b1, 2'd0,                1'b0, P0};

    nvdla_core_rstn = 1'b0;
    pipe_if.in_vld  = 1'b0;
    pipe_if.out_rdy = 1'b0;
    pipe_if.in_pd   = '0;
    repeat (2) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      pipe_if.in_vld  = vecs[i].in_vld;
      pipe_if.out_rdy = vecs[i].out_rdy;
      pipe_if.in_pd   = vecs[i].in_pd;
      @(negedge nvdla_core_clk);
      $display("vec %0d: in_vld=%0b out_rdy=%0b out_vld=%0b in_rdy=%0b level=%0d afull=%0b",
               i, pipe_if.in_vld, pipe_if.out_rdy, pipe_if.out_vld, pipe_if.in_rdy,
               pipe_if.level, pipe_if.afull);
      chk($sformatf("vec%0d out_vld", i), W'(pipe_if.out_vld), W'(vecs[i].e_out_vld));
      chk($sformatf("vec%0d in_rdy", i),  W'(pipe_if.in_rdy),  W'(vecs[i].e_in_rdy));
      chk($sformatf("vec%0d level", i),   W'(pipe_if.level),   W'(vecs[i].e_level));
      chk($sformatf("vec%0d afull", i),   W'(pipe_if.afull),   W'(vecs[i].e_afull));
      if (vecs[i].e_out_vld) begin
        chk($sformatf("vec%0d out_pd", i), pipe_if.out_pd, vecs[i].e_pd);
      end
      tick();
    end

    // Ten back-to-back pushes with random downstream stalls: FIFO order and hold.
    sent   = 0;
    got    = 0;
    hold_v = 1'b0;
    hold_pd = '0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      pipe_if.in_vld  = (sent < 10);
      pipe_if.in_pd   = W'(sent);
      pipe_if.out_rdy = 1'($urandom_range(0, 1));
      @(negedge nvdla_core_clk);
      if (hold_v) begin
        chk("hold out_vld", W'(pipe_if.out_vld), W'(1'b1));
        chk("hold out_pd", pipe_if.out_pd, hold_pd);
      end
      hold_v  = pipe_if.out_vld & ~pipe_if.out_rdy;
      hold_pd = pipe_if.out_pd;
      if (pipe_if.out_vld && pipe_if.out_rdy) begin
        $display("pop: pd=%0h expected=%0d", pipe_if.out_pd, got);
        chk("order", pipe_if.out_pd, W'(got));
        got++;
      end
      if (pipe_if.in_vld && pipe_if.in_rdy) sent++;
      tick();
    end
    chk("drain count", W'(got), W'(10));
    pipe_if.in_vld  = 1'b0;
    pipe_if.out_rdy = 1'b0;
    @(negedge nvdla_core_clk);
    chk("drained level", W'(pipe_if.level), W'(0));
    tick();

    // Asynchronous reset with two entries held; push during reset is discarded.
    pipe_if.in_vld = 1'b1;
    pipe_if.in_pd  = A0;
    tick();
    pipe_if.in_pd  = A1;
    tick();
    chk("pre-reset level", W'(pipe_if.level), W'(2));
    #2;
    nvdla_core_rstn = 1'b0;
    #1;
    $display("reset: level=%0d out_vld=%0b in_rdy=%0b", pipe_if.level, pipe_if.out_vld, pipe_if.in_rdy);
    chk("reset level", W'(pipe_if.level), W'(0));
    chk("reset out_vld", W'(pipe_if.out_vld), W'(BYP));
    chk("reset in_rdy", W'(pipe_if.in_rdy), W'(1'b1));
    chk("reset afull", W'(pipe_if.afull), W'(1'b0));
    tick();
    pipe_if.in_vld = 1'b0;
    #2;
    nvdla_core_rstn = 1'b1;
    @(negedge nvdla_core_clk);
    chk("post-reset level", W'(pipe_if.level), W'(0));
    chk("post-reset out_vld", W'(pipe_if.out_vld), W'(1'b0));
    tick();

`ifdef NV_NVDLA_MCIF_PIPE_BYPASS_EN
    pipe_if.in_vld  = 1'b1;
    pipe_if.out_rdy = 1'b1;
    pipe_if.in_pd   = 75'hAB;
    @(negedge nvdla_core_clk);
    $display("bypass: out_vld=%0b pd=%0h level=%0d", pipe_if.out_vld, pipe_if.out_pd, pipe_if.level);
    chk("bypass out_vld", W'(pipe_if.out_vld), W'(1'b1));
    chk("bypass out_pd", pipe_if.out_pd, 75'hAB);
    tick();
    pipe_if.in_vld = 1'b0;
    @(negedge nvdla_core_clk);
    chk("bypass level", W'(pipe_if.level), W'(0));
    chk("bypass after out_vld", W'(pipe_if.out_vld), W'(1'b0));
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
